fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests one word at PC, holds it for execution, then steers PC.
// Latency: one FETCH cycle from request to instr_valid when memory answers with ready+rvalid together.
// Backpressure: waits indefinitely on imem_ready/imem_rvalid and on exec_done; one request in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        misalign_q;
    logic [31:0] next_pc_d;

    // Next-PC selection for the instruction currently held in ISSUE; sums wrap silently.
    always_comb begin
        next_pc_d = pc_q + 32'd4;
        case (PCSrc)
            2'b01:   next_pc_d = pc_q + ImmExt;
            2'b10:   next_pc_d = ALUResult & 32'hFFFF_FFFE;
            default: next_pc_d = pc_q + 32'd4;
        endcase
    end

    // Fetch state machine; request and valid flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    // rvalid without ready here is stale traffic and is dropped.
                    if (imem_ready) begin
                        req_q <= 1'b0;
                        if (imem_rvalid) begin
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        // A misaligned target still loads so the faulting PC is visible.
                        if (next_pc_d[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            state_q    <= HALT;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = req_q ? pc_q : 32'h0000_0000;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign instr_valid = valid_q;
    assign misalign    = misalign_q;

endmodule
